// File: rtl/decode_pkg.sv
// Shared RV32I/RV32E decode constants and the decoded-instruction bundle.
// Used by the combinational decoder and the registered decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic        re1;
    logic        re2;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        dec;
  } ent_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational field extraction, immediates, register enables and
// legality checking for one raw instruction word.
module decode_comb
  import decode_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        is_lui;
  logic        is_auipc;
  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic        is_load;
  logic        is_store;
  logic        is_opimm;
  logic        is_op;
  logic        is_fence;
  logic        is_system;
  logic        f7_ok;
  logic        we_raw;
  logic        re1_raw;
  logic        re2_raw;
  logic        legal;
  logic        e_bad;
  logic        illegal;
  logic [2:0]  fmt_raw;
  logic [31:0] imm_raw;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  assign imm_i = sext12(instr[31:20]);
  assign imm_s = sext12({instr[31:25], instr[11:7]});
  assign imm_b = {{20{instr[31]}}, instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign is_lui    = (op == OPC_LUI);
  assign is_auipc  = (op == OPC_AUIPC);
  assign is_jal    = (op == OPC_JAL);
  assign is_jalr   = (op == OPC_JALR);
  assign is_branch = (op == OPC_BRANCH);
  assign is_load   = (op == OPC_LOAD);
  assign is_store  = (op == OPC_STORE);
  assign is_opimm  = (op == OPC_OP_IMM);
  assign is_op     = (op == OPC_OP);
  assign is_fence  = (op == OPC_FENCE);
  assign is_system = (op == OPC_SYSTEM);

  assign f7_ok = (f7 == F7_ZERO) || (f7 == F7_ALT);

  always_comb begin
    we_raw  = 1'b0;
    re1_raw = 1'b0;
    re2_raw = 1'b0;
    legal   = 1'b1;
    fmt_raw = FMT_NONE;
    imm_raw = '0;
    unique case (1'b1)
      is_lui, is_auipc: begin
        we_raw  = 1'b1;
        fmt_raw = FMT_U;
        imm_raw = imm_u;
      end
      is_jal: begin
        we_raw  = 1'b1;
        fmt_raw = FMT_J;
        imm_raw = imm_j;
      end
      is_jalr: begin
        we_raw  = 1'b1;
        re1_raw = 1'b1;
        fmt_raw = FMT_I;
        imm_raw = imm_i;
        legal   = (f3 == 3'b000);
      end
      is_load: begin
        we_raw  = 1'b1;
        re1_raw = 1'b1;
        fmt_raw = FMT_I;
        imm_raw = imm_i;
        legal   = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      end
      is_opimm: begin
        we_raw  = 1'b1;
        re1_raw = 1'b1;
        fmt_raw = FMT_I;
        imm_raw = imm_i;
        legal   = !((f3 == 3'b001) && (f7 != F7_ZERO)) &&
                  !((f3 == 3'b101) && !f7_ok);
      end
      is_branch: begin
        re1_raw = 1'b1;
        re2_raw = 1'b1;
        fmt_raw = FMT_B;
        imm_raw = imm_b;
        legal   = (f3[2:1] != 2'b01);
      end
      is_store: begin
        re1_raw = 1'b1;
        re2_raw = 1'b1;
        fmt_raw = FMT_S;
        imm_raw = imm_s;
        legal   = (f3 < 3'd3);
      end
      is_op: begin
        we_raw  = 1'b1;
        re1_raw = 1'b1;
        re2_raw = 1'b1;
        fmt_raw = FMT_R;
        legal   = f7_ok &&
                  !((f7 == F7_ALT) && (f3 != 3'b000) &&
                    (f3 != 3'b101));
      end
      is_fence, is_system: begin
        legal = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // RV32E only has x0-x15: any referenced register above that is illegal
  assign e_bad = (REG_AW == 4) &&
                 ((we_raw  && instr[11]) ||
                  (re1_raw && instr[19]) ||
                  (re2_raw && instr[24]));

  assign illegal = !legal || e_bad;

  always_comb begin
    dec.opcode  = op;
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.illegal = illegal;
    dec.we      = we_raw && !illegal && (instr[11:7] != 5'd0);
    dec.re1     = re1_raw && !illegal;
    dec.re2     = re2_raw && !illegal;
    dec.imm     = illegal ? '0 : imm_raw;
    dec.fmt     = illegal ? FMT_NONE : fmt_raw;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus one skid entry so that
// in_ready can be a flop while still sustaining one instruction per cycle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [REG_AW-1:0] rd_addr,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  output logic              rg_we,
  output logic              rg_re1,
  output logic              rg_re2,
  output logic [XLEN-1:0]   imm,
  output logic [2:0]        fmt,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_e;

  state_e st_q;
  state_e st_d;
  ent_t   out_q;
  ent_t   out_d;
  ent_t   skid_q;
  ent_t   skid_d;
  ent_t   new_e;
  dec_t   dec;
  logic   in_ready_q;
  logic   in_ready_d;
  logic   out_valid_q;
  logic   out_valid_d;
  logic   acc;
  logic   hs;

  decode_comb #(
    .REG_AW(REG_AW)
  ) u_comb (
    .instr(in_instr),
    .dec  (dec)
  );

  always_comb begin
    new_e.pc  = in_pc;
    new_e.dec = dec;
  end

  assign acc = in_valid && in_ready_q;
  assign hs  = out_valid_q && out_ready;

  always_comb begin
    st_d   = st_q;
    out_d  = out_q;
    skid_d = skid_q;
    if (flush) begin
      st_d = S_EMPTY;
    end else begin
      unique case (st_q)
        S_EMPTY: begin
          if (acc) begin
            st_d  = S_ONE;
            out_d = new_e;
          end
        end
        S_ONE: begin
          if (acc && hs) begin
            out_d = new_e;
          end else if (acc) begin
            st_d   = S_TWO;
            skid_d = new_e;
          end else if (hs) begin
            st_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (hs) begin
            st_d  = S_ONE;
            out_d = skid_q;
          end
        end
        default: begin
          st_d = S_EMPTY;
        end
      endcase
    end
    out_valid_d = (st_d != S_EMPTY);
    in_ready_d  = (st_d != S_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= S_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      st_q        <= st_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign opcode    = out_q.dec.opcode;
  assign funct3    = out_q.dec.funct3;
  assign funct7    = out_q.dec.funct7;
  assign rd_addr   = out_q.dec.rd[REG_AW-1:0];
  assign rs1_addr  = out_q.dec.rs1[REG_AW-1:0];
  assign rs2_addr  = out_q.dec.rs2[REG_AW-1:0];
  assign rg_we     = out_q.dec.we;
  assign rg_re1    = out_q.dec.re1;
  assign rg_re2    = out_q.dec.re2;
  assign imm       = out_q.dec.imm;
  assign fmt       = out_q.dec.fmt;
  assign illegal   = out_q.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32I and RV32E instances share one stimulus
// stream and are compared against a queue-based decode reference.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready5, out_valid5, we5, re15, re25, ill5;
  logic [31:0] out_pc5, imm5;
  logic [6:0]  op5, f75;
  logic [2:0]  f35, fmt5;
  logic [4:0]  rd5, rs15, rs25;

  logic        in_ready4, out_valid4, we4, re14, re24, ill4;
  logic [31:0] out_pc4, imm4;
  logic [6:0]  op4, f74;
  logic [2:0]  f34, fmt4;
  logic [3:0]  rd4, rs14, rs24;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_AW(5)) u5 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready5),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid5), .out_ready(out_ready),
    .out_pc(out_pc5), .opcode(op5), .funct3(f35), .funct7(f75),
    .rd_addr(rd5), .rs1_addr(rs15), .rs2_addr(rs25),
    .rg_we(we5), .rg_re1(re15), .rg_re2(re25),
    .imm(imm5), .fmt(fmt5), .illegal(ill5)
  );

  decode_stage #(.XLEN(32), .REG_AW(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_pc(out_pc4), .opcode(op4), .funct3(f34), .funct7(f74),
    .rd_addr(rd4), .rs1_addr(rs14), .rs2_addr(rs24),
    .rg_we(we4), .rg_re1(re14), .rg_re2(re24),
    .imm(imm4), .fmt(fmt4), .illegal(ill4)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic        re1;
    logic        re2;
    logic        ill;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } item_t;

  item_t       q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] w,
                                   input logic [31:0] pc,
                                   input int aw);
    exp_t e;
    int   f3, f7, iv, sv;
    bit   ok, ur, u1, u2;
    int   val;
    logic [4:0] m;
    m  = (aw == 4) ? 5'h0f : 5'h1f;
    e  = '0;
    e.pc = pc;
    e.op = w[6:0];
    e.f3 = w[14:12];
    e.f7 = w[31:25];
    e.rd  = w[11:7] & m;
    e.rs1 = w[19:15] & m;
    e.rs2 = w[24:20] & m;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    iv = (w[31] ? -2048 : 0) + int'(w[30:20]);
    sv = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
    ok = 1; ur = 0; u1 = 0; u2 = 0; val = 0;
    e.fmt = FMT_NONE;
    case (w[6:0])
      7'h37, 7'h17: begin
        ur = 1; e.fmt = FMT_U; val = int'(w & 32'hfffff000);
      end
      7'h6f: begin
        ur = 1; e.fmt = FMT_J;
        val = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 +
              int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      end
      7'h67: begin
        ur = 1; u1 = 1; e.fmt = FMT_I; val = iv; ok = (f3 == 0);
      end
      7'h03: begin
        ur = 1; u1 = 1; e.fmt = FMT_I; val = iv;
        ok = f3 inside {0, 1, 2, 4, 5};
      end
      7'h13: begin
        ur = 1; u1 = 1; e.fmt = FMT_I; val = iv;
        ok = !(f3 == 1 && f7 != 0) && !(f3 == 5 && !(f7 inside {0, 32}));
      end
      7'h63: begin
        u1 = 1; u2 = 1; e.fmt = FMT_B; ok = !(f3 inside {2, 3});
        val = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 +
              int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end
      7'h23: begin
        u1 = 1; u2 = 1; e.fmt = FMT_S; val = sv; ok = (f3 < 3);
      end
      7'h33: begin
        ur = 1; u1 = 1; u2 = 1; e.fmt = FMT_R;
        ok = (f7 == 0) || (f7 == 32 && (f3 inside {0, 5}));
      end
      7'h0f, 7'h73: ok = 1;
      default: ok = 0;
    endcase
    if (aw == 4 && ((ur && w[11]) || (u1 && w[19]) || (u2 && w[24])))
      ok = 0;
    e.ill = !ok;
    if (ok) begin
      e.we  = ur && (w[11:7] != 0);
      e.re1 = u1;
      e.re2 = u2;
      e.imm = val;
    end else begin
      e.fmt = FMT_NONE;
    end
    return e;
  endfunction

  task automatic verify();
    exp_t e;
    check("vld5", out_valid5, q.size() > 0);
    check("rdy5", in_ready5, q.size() < 2);
    check("vld4", out_valid4, q.size() > 0);
    check("rdy4", in_ready4, q.size() < 2);
    if (q.size() > 0) begin
      e = ref_dec(q[0].w, q[0].pc, 5);
      check("pc5", out_pc5, e.pc);
      check("imm5", imm5, e.imm);
      check("fn5", {op5, f35, f75}, {e.op, e.f3, e.f7});
      check("reg5", {rd5, rs15, rs25}, {e.rd, e.rs1, e.rs2});
      check("ctl5", {we5, re15, re25, ill5, fmt5},
            {e.we, e.re1, e.re2, e.ill, e.fmt});
      e = ref_dec(q[0].w, q[0].pc, 4);
      check("pc4", out_pc4, e.pc);
      check("imm4", imm4, e.imm);
      check("reg4", {rd4, rs14, rs24},
            {e.rd[3:0], e.rs1[3:0], e.rs2[3:0]});
      check("ctl4", {we4, re14, re24, ill4, fmt4},
            {e.we, e.re1, e.re2, e.ill, e.fmt});
    end
  endtask

  // Drive one cycle from a negedge, update the model at the posedge,
  // and compare at the following negedge.
  task automatic cycle(input bit iv, input logic [31:0] w,
                       input bit ordy, input bit fl, output bit acc);
    bit    hs;
    item_t it;
    in_valid  = iv;
    in_instr  = w;
    in_pc     = pc_ctr;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (q.size() < 2) && !fl;
    hs  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (hs) void'(q.pop_front());
      if (acc) begin
        it.w  = w;
        it.pc = pc_ctr;
        q.push_back(it);
      end
    end
    pc_ctr += 4;
    @(negedge clk);
    verify();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [6:0]  ops[11];
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
    w = $urandom;
    if ($urandom_range(7) != 0) w[6:0] = ops[$urandom_range(10)];
    if ($urandom_range(1) != 0)
      w[31:25] = ($urandom_range(1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(1) != 0) begin
      w[11] = 1'b0;
      w[19] = 1'b0;
      w[24] = 1'b0;
    end
    return w;
  endfunction

  initial begin
    bit          a;
    logic [31:0] bp[4];
    logic [31:0] cur;
    bit          have;
    int          k;
    int          n;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #3;
    check("rst_vld", out_valid5, 0);
    check("rst_rdy", in_ready5, 1);
    check("rst_imm", imm5, 0);
    check("rst_pc", out_pc5, 0);
    @(negedge clk);
    rst = 1'b0;
    verify();

    cycle(1, 32'h00500093, 1, 0, a);
    check("addi_imm", imm5, 5);
    check("addi_rd", rd5, 1);
    check("addi_ctl", {we5, re15, re25, ill5}, 4'b1100);
    cycle(1, 32'hfe000ee3, 1, 0, a);
    check("beq_imm", imm5, 32'hfffffffc);
    check("beq_fmt", fmt5, FMT_B);
    check("beq_en", {we5, re15, re25}, 3'b011);
    cycle(1, 32'h00000013, 1, 0, a);
    check("nop_ctl", {we5, ill5}, 2'b00);
    cycle(1, 32'h00000000, 1, 0, a);
    check("zero_ctl", {ill5, we5, re15, re25}, 4'b1000);
    cycle(1, 32'h00208833, 1, 0, a);
    check("e_ill", {ill4, we4}, 2'b10);
    check("i_add", {ill5, rd5}, {1'b0, 5'd16});
    cycle(0, 32'h0, 1, 0, a);

    bp = '{32'h00100093, 32'h00200113, 32'h002081b3, 32'h40310233};
    k = 0;
    n = 0;
    while (k < 4 && n < 20) begin
      cycle(1, bp[k], n >= 3, 0, a);
      if (a) k++;
      if (n == 1) check("bp_rdy", in_ready5, 0);
      n++;
    end
    check("bp_all", k, 4);
    repeat (3) cycle(0, 32'h0, 1, 0, a);

    cycle(1, 32'h00100093, 0, 0, a);
    cycle(1, 32'h00200113, 0, 0, a);
    check("two_rdy", in_ready5, 0);
    cycle(1, 32'h00300193, 1, 1, a);
    check("fl_vld", out_valid5, 0);
    check("fl_rdy", in_ready5, 1);
    repeat (3) cycle(0, 32'h0, 1, 0, a);

    have = 0;
    cur = '0;
    for (int i = 0; i < 800; i++) begin
      if (!have) cur = rnd_instr();
      have = have || ($urandom_range(3) != 0);
      cycle(have, cur, $urandom_range(2) != 0,
            $urandom_range(49) == 0, a);
      if (a) have = 0;
    end

    cycle(1, 32'h00100093, 0, 0, a);
    cycle(1, 32'h00200113, 0, 0, a);
    #2;
    rst = 1'b1;
    #1;
    check("arst_vld", out_valid5, 0);
    check("arst_rdy", in_ready5, 1);
    check("arst_imm", imm5, 0);
    check("arst_pc", out_pc5, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    verify();
    repeat (4) cycle(1, rnd_instr(), 1, 0, a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
